alu_serial_ctrl: RTL

Bit-serial sequencer that drives a single external 1-bit ALU slice to perform a full WIDTH-bit operation. It latches operands and the 4-bit ALU operation code, then presents one bit pair per cycle, LSB first. It chains the slice's carry-out back into its carry-in and shifts the slice result into a WIDTH-bit result register. It sits between the datapath and a shared slice, and acts as the initiator side of the slice interface: the slice is the responder.

---
 rtl/alu_serial_ctrl_if.sv | 43 ++++
 rtl/alu_serial_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl_if.sv
// alu_serial_ctrl_if: groups the datapath request/response and the 1-bit
// slice signals of alu_serial_ctrl.
//   master : controller view. Receives start/operands/op and the slice
//            results; drives status, result, flags and the slice operands.
//   slave  : environment view (datapath plus the external slice).
// The controller is the initiator on the slice side, so it takes the master
// modport.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 64
);
  // datapath request
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       alu_op;
  // datapath response
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             op_error;
  // slice side
  logic             slice_a;
  logic             slice_b;
  logic             slice_carry_in;
  logic [3:0]       slice_alu_op;
  logic             slice_result;
  logic             slice_carry_out;

  modport master (
    input  start, a_in, b_in, alu_op, slice_result, slice_carry_out,
    output busy, done, result, carry_out, overflow, zero, op_error,
           slice_a, slice_b, slice_carry_in, slice_alu_op
  );

  modport slave (
    output start, a_in, b_in, alu_op, slice_result, slice_carry_out,
    input  busy, done, result, carry_out, overflow, zero, op_error,
           slice_a, slice_b, slice_carry_in, slice_alu_op
  );
endinterface

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer that runs a WIDTH-bit AND/OR/ADD
// (with optional A invert / B negate) through one external 1-bit ALU slice,
// LSB first, chaining the slice carry-out back into the next carry-in.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : alu_serial_ctrl_if.master (datapath request/response + slice)
// Timing: accepted start -> done pulse WIDTH+1 cycles later (RUN is WIDTH
// cycles, then a one-cycle DONE). Illegal op goes straight to DONE.
module alu_serial_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic                clk,
  input  logic                reset,
  alu_serial_ctrl_if.master   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;     // operand shift registers, bit 0 = current bit
  logic [3:0]       op_q;
  logic [CW-1:0]    idx_q;
  logic             cy_q;         // carry into the current bit
  logic [WIDTH-1:0] res_q;
  logic             cout_q, ovf_q, err_q;

  logic last_bit, illegal_in, is_add;

  assign last_bit   = (idx_q == CW'(WIDTH-1));
  assign illegal_in = (bus.alu_op[1:0] == 2'b11);
  assign is_add     = (op_q[1:0] == 2'b10);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = illegal_in ? S_DONE : S_RUN;
      S_RUN:  if (last_bit)  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      idx_q  <= '0;
      cy_q   <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            if (illegal_in) begin
              // An illegal op never reaches the slice, so the slice-facing
              // registers keep their previous values.
              err_q <= 1'b1;
            end else begin
              err_q <= 1'b0;
              a_q   <= bus.a_in;
              b_q   <= bus.b_in;
              op_q  <= bus.alu_op;
              idx_q <= '0;
              cy_q  <= bus.alu_op[2];  // Bnegate supplies the +1 of two's complement
            end
          end
        end
        S_RUN: begin
          res_q[idx_q] <= bus.slice_result;
          if (last_bit) begin
            // cy_q is the carry into the MSB here; operands and carry are not
            // advanced so the slice outputs hold their last-bit values.
            cout_q <= is_add & bus.slice_carry_out;
            ovf_q  <= is_add & (cy_q ^ bus.slice_carry_out);
          end else begin
            idx_q <= idx_q + 1'b1;
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            if (is_add) cy_q <= bus.slice_carry_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.result         = res_q;
  assign bus.carry_out      = cout_q;
  assign bus.overflow       = ovf_q;
  assign bus.zero           = (res_q == '0);
  assign bus.op_error       = err_q;
  assign bus.slice_a        = a_q[0];
  assign bus.slice_b        = b_q[0];
  assign bus.slice_carry_in = cy_q;
  assign bus.slice_alu_op   = op_q;
endmodule
